// File: rtl/asic_frame_responder.sv
// asic_frame_responder: a serial frame responder for an ASIC-side link.
// Receives FRAME_BITS-bit frames on DTX and returns a queued word (or
// IDLE_WORD) on DRX, both MSB first.
// Optional build macro FRAME_ECHO_EN adds an echo_en input. When it is set
// at frame load, the block transmits the last received frame instead of the
// queued word.
module asic_frame_responder #(
    parameter int          FRAME_BITS = 32,
    parameter logic [31:0] IDLE_WORD  = 32'h0000_0000
) (
    input  logic                  MCK,
    input  logic                  RST_N,
    input  logic                  DSYNC,
    input  logic                  DTX,
    output logic                  DRX,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  sync_err,
    output logic                  frame_active
`ifdef FRAME_ECHO_EN
    ,
    input  logic                  echo_en
`endif
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] IDLE_W = IDLE_WORD[FRAME_BITS-1:0];

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [FRAME_BITS-1:0]   rx_shift_reg;
    logic [FRAME_BITS-1:0]   tx_shift_reg;
    logic [FRAME_BITS-1:0]   hold_reg;
    logic                    hold_full_reg;

    logic                    frame_load;
    logic                    frame_done;
    logic                    frame_abort;
    logic                    echo_sel;
    logic                    take_hold;
    logic                    underrun_next;
    logic [FRAME_BITS-1:0]   tx_word;

    assign tx_ready     = ~hold_full_reg;
    assign frame_active = (state_reg == SHIFT);

    // FSM state and bit counter registers
    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and per-edge frame events (load / done / abort)
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        frame_load  = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (DSYNC) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    frame_load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_BIT) begin
                    // All bits are in; a DSYNC on this edge chains the next frame
                    frame_done = 1'b1;
                    cnt_next   = '0;
                    if (DSYNC) begin
                        frame_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (DSYNC) begin
                    // Early DSYNC: drop the partial frame and realign here
                    frame_abort = 1'b1;
                    frame_load  = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Source selection for the word loaded at frame start
    always_comb begin
`ifdef FRAME_ECHO_EN
        echo_sel = echo_en;
`else
        echo_sel = 1'b0;
`endif
        take_hold     = frame_load & ~echo_sel & hold_full_reg;
        underrun_next = frame_load & ~echo_sel & ~hold_full_reg;
        if (echo_sel) begin
            tx_word = rx_data;
        end else if (hold_full_reg) begin
            tx_word = hold_reg;
        end else begin
            tx_word = IDLE_W;
        end
    end

    // Shift datapath, received-frame output, status pulses and TX holding register
    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            DRX           <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_underrun   <= 1'b0;
            sync_err      <= 1'b0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            rx_valid    <= frame_done;
            sync_err    <= frame_abort;
            tx_underrun <= underrun_next;
            if (frame_done) begin
                rx_data <= rx_shift_reg;
            end
            if (frame_load) begin
                rx_shift_reg <= {{(FRAME_BITS-1){1'b0}}, DTX};
                DRX          <= tx_word[FRAME_BITS-1];
                tx_shift_reg <= tx_word << 1;
            end else if (state_reg == SHIFT && !frame_done) begin
                rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], DTX};
                DRX          <= tx_shift_reg[FRAME_BITS-1];
                tx_shift_reg <= tx_shift_reg << 1;
            end else begin
                DRX <= 1'b0;
            end
            // A full register blocks tx_ready, so a handshake and a take never coincide
            if (take_hold) begin
                hold_full_reg <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_asic_frame_responder.sv
// Scoreboard testbench for asic_frame_responder (FRAME_BITS=32).
// Stimulus pushes expected DRX words and rx_data words into queues; a
// negedge monitor pops and compares them as the DUT presents them.
module tb_asic_frame_responder;

    localparam logic [31:0] IDLE_W = 32'hC3C3_3C3C;

    logic        tb_ACLK = 1'b0;
    logic        RST_N;
    logic        DSYNC;
    logic        DTX;
    logic        DRX;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_underrun;
    logic        sync_err;
    logic        frame_active;
`ifdef FRAME_ECHO_EN
    logic        echo_en;
`endif

    asic_frame_responder #(
        .FRAME_BITS (32),
        .IDLE_WORD  (IDLE_W)
    ) dut (
        .MCK          (tb_ACLK),
        .RST_N        (RST_N),
        .DSYNC        (DSYNC),
        .DTX          (DTX),
        .DRX          (DRX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_underrun  (tx_underrun),
        .sync_err     (sync_err),
        .frame_active (frame_active)
`ifdef FRAME_ECHO_EN
        ,
        .echo_en      (echo_en)
`endif
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int checks = 0;
    int passes = 0;
    logic [31:0] tx_exp[$];
    logic [31:0] rx_exp[$];
    int underrun_cnt = 0;
    int sync_cnt     = 0;
    int idle_drx_bad = 0;
    int bit_cnt      = 0;
    logic [31:0] drx_word = '0;
    logic f_underrun, f_sync, f_active, f_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("check %-22s got %08h", name, act);
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic expect_frame(input logic [31:0] txw, input logic [31:0] rxw);
        tx_exp.push_back(txw);
        rx_exp.push_back(rxw);
    endtask

    // Call at a negedge: DSYNC with the MSB, then nbits-1 further DTX bits
    task automatic start_frame(input logic [31:0] w, input int nbits);
        DSYNC = 1'b1;
        DTX   = w[31];
        @(negedge tb_ACLK);
        f_underrun = tx_underrun;
        f_sync     = sync_err;
        f_active   = frame_active;
        f_ready    = tx_ready;
        DSYNC = 1'b0;
        for (int k = 1; k < nbits; k++) begin
            DTX = w[31-k];
            @(negedge tb_ACLK);
        end
    endtask

    task automatic idle_cycles(input int n);
        DSYNC = 1'b0;
        DTX   = 1'b0;
        repeat (n) @(negedge tb_ACLK);
    endtask

    task automatic push_tx(input logic [31:0] w);
        int n;
        n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL push_tx_timeout: tx_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge tb_ACLK);
        tx_valid = 1'b0;
    endtask

    // Monitor: rx_valid pops rx_exp; 32 DRX bits while frame_active pop tx_exp
    always @(negedge tb_ACLK) begin
        if (!RST_N) begin
            bit_cnt = 0;
        end else begin
            if (rx_valid) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    $display("FAIL rx_unexpected: rx_valid with rx_data %08h, none required", rx_data);
                end else begin
                    check("rx_data", rx_data, rx_exp.pop_front());
                end
            end
            if (sync_err) begin
                bit_cnt = 0;
                sync_cnt++;
            end
            if (tx_underrun) underrun_cnt++;
            if (frame_active) begin
                drx_word = {drx_word[30:0], DRX};
                bit_cnt++;
                if (bit_cnt == 32) begin
                    bit_cnt = 0;
                    if (tx_exp.size() == 0) begin
                        checks++;
                        $display("FAIL drx_unexpected: DRX word %08h, none required", drx_word);
                    end else begin
                        check("drx_word", drx_word, tx_exp.pop_front());
                    end
                end
            end else begin
                bit_cnt = 0;
                if (DRX !== 1'b0) idle_drx_bad++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int u0, s0;
        RST_N    = 1'b0;
        DSYNC    = 1'b0;
        DTX      = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
`ifdef FRAME_ECHO_EN
        echo_en  = 1'b0;
`endif
        repeat (3) @(negedge tb_ACLK);
        check_bit("rst_DRX", DRX, 1'b0);
        check("rst_rx_data", rx_data, 32'h0);
        check_bit("rst_rx_valid", rx_valid, 1'b0);
        check_bit("rst_tx_ready", tx_ready, 1'b1);
        check_bit("rst_tx_underrun", tx_underrun, 1'b0);
        check_bit("rst_sync_err", sync_err, 1'b0);
        check_bit("rst_frame_active", frame_active, 1'b0);
        RST_N = 1'b1;
        idle_cycles(2);

        // Queued word A5A50F0F, receive 12345678
        push_tx(32'hA5A5_0F0F);
        check_bit("t1_ready_full", tx_ready, 1'b0);
        expect_frame(32'hA5A5_0F0F, 32'h1234_5678);
        u0 = underrun_cnt;
        start_frame(32'h1234_5678, 32);
        check_bit("t1_active", f_active, 1'b1);
        check_bit("t1_ready_emptied", f_ready, 1'b1);
        idle_cycles(1);
        check_bit("t1_rx_valid_n32", rx_valid, 1'b1);
        idle_cycles(2);
        check("t1_underruns", underrun_cnt - u0, 0);
        check("t1_rx_data_held", rx_data, 32'h1234_5678);

        // Empty queue -> IDLE_WORD and one underrun pulse after edge N
        expect_frame(IDLE_W, 32'h0F0F_1234);
        u0 = underrun_cnt;
        start_frame(32'h0F0F_1234, 32);
        check_bit("t2_underrun_n1", f_underrun, 1'b1);
        idle_cycles(3);
        check("t2_underruns", underrun_cnt - u0, 1);

        // DSYNC again at N+10 -> abort, realign
        push_tx(32'h1111_2222);
        expect_frame(IDLE_W, 32'h8765_4321);
        s0 = sync_cnt;
        start_frame(32'hFFFF_FFFF, 10);
        start_frame(32'h8765_4321, 32);
        check_bit("t3_sync_err", f_sync, 1'b1);
        check_bit("t3_underrun", f_underrun, 1'b1);
        idle_cycles(3);
        check("t3_sync_pulses", sync_cnt - s0, 1);

        // Back-to-back frames with words 1 and 2
        push_tx(32'h0000_0001);
        expect_frame(32'h0000_0001, 32'hCAFE_0001);
        expect_frame(32'h0000_0002, 32'hCAFE_0002);
        u0 = underrun_cnt;
        s0 = sync_cnt;
        fork
            begin
                start_frame(32'hCAFE_0001, 32);
                start_frame(32'hCAFE_0002, 32);
            end
            begin
                repeat (3) @(negedge tb_ACLK);
                push_tx(32'h0000_0002);
            end
        join
        check_bit("t4_active_b2b", f_active, 1'b1);
        idle_cycles(3);
        check("t4_underruns", underrun_cnt - u0, 0);
        check("t4_sync_pulses", sync_cnt - s0, 0);

        // Handshake on the load edge is queued for the next frame
        expect_frame(IDLE_W, 32'h0123_4567);
        expect_frame(32'h3333_4444, 32'h89AB_CDEF);
        u0 = underrun_cnt;
        tx_data  = 32'h3333_4444;
        tx_valid = 1'b1;
        fork
            begin
                start_frame(32'h0123_4567, 32);
                start_frame(32'h89AB_CDEF, 32);
            end
            begin
                @(negedge tb_ACLK);
                tx_valid = 1'b0;
            end
        join
        idle_cycles(3);
        check("t5_underruns", underrun_cnt - u0, 1);

        // Reset mid-frame: abort and lose the queued word
        push_tx(32'h5555_AAAA);
        fork
            start_frame(32'h7E7E_7E7E, 15);
            begin
                repeat (2) @(negedge tb_ACLK);
                push_tx(32'h7777_8888);
            end
        join
        check_bit("t6_ready_before_rst", tx_ready, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check_bit("t6_DRX", DRX, 1'b0);
        check("t6_rx_data", rx_data, 32'h0);
        check_bit("t6_tx_ready", tx_ready, 1'b1);
        check_bit("t6_frame_active", frame_active, 1'b0);
        check_bit("t6_rx_valid", rx_valid, 1'b0);
        @(negedge tb_ACLK);
        #2;
        RST_N = 1'b1;
        @(negedge tb_ACLK);
        expect_frame(IDLE_W, 32'h2468_ACE0);
        start_frame(32'h2468_ACE0, 32);
        check_bit("t6_underrun_after", f_underrun, 1'b1);
        idle_cycles(3);

`ifdef FRAME_ECHO_EN
        // Echo the last received frame; holding register untouched
        expect_frame(IDLE_W, 32'hDEAD_BEEF);
        start_frame(32'hDEAD_BEEF, 32);
        idle_cycles(2);
        push_tx(32'h0BAD_F00D);
        echo_en = 1'b1;
        expect_frame(32'hDEAD_BEEF, 32'h0102_0304);
        start_frame(32'h0102_0304, 32);
        echo_en = 1'b0;
        check_bit("t7_ready_unchanged", f_ready, 1'b0);
        check_bit("t7_no_underrun", f_underrun, 1'b0);
        idle_cycles(2);
        expect_frame(32'h0BAD_F00D, 32'h0506_0708);
        start_frame(32'h0506_0708, 32);
        idle_cycles(3);
`endif

        check("tx_queue_drained", tx_exp.size(), 0);
        check("rx_queue_drained", rx_exp.size(), 0);
        check("idle_drx_nonzero", idle_drx_bad, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
